// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the up/down Gray counter and its bench.
// Values are carried as 32-bit vectors; `width` selects the live low bits.
package gray_pkg;

  localparam int unsigned GRAY_MAX_WIDTH = 32;

  function automatic logic [GRAY_MAX_WIDTH-1:0] width_mask(input int unsigned width);
    return (width >= GRAY_MAX_WIDTH) ? {GRAY_MAX_WIDTH{1'b1}} :
                                       ((32'd1 << width) - 32'd1);
  endfunction

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b,
                                                         input int unsigned width);
    logic [GRAY_MAX_WIDTH-1:0] bm;
    bm = b & width_mask(width);
    return bm ^ (bm >> 1);
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g,
                                                         input int unsigned width);
    logic [GRAY_MAX_WIDTH-1:0] gm;
    logic [GRAY_MAX_WIDTH-1:0] b;
    gm = g & width_mask(width);
    b = '0;
    b[GRAY_MAX_WIDTH-1] = gm[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_ud_if.sv
// Control and result bundle of the up/down Gray counter.
// master drives the controls, slave is the counter itself.
interface gray_counter_ud_if #(
  parameter int unsigned WIDTH = 4
);
  logic             ena;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_bin;
  logic             tc;
  logic             wrap;

  modport master (
    output ena, up, clr, load, load_val,
    input  count, count_bin, tc, wrap
  );

  modport slave (
    input  ena, up, clr, load, load_val,
    output count, count_bin, tc, wrap
  );
endinterface

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter: bit i is the XOR of all Gray bits at or above i.
module gray2bin_conv #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_counter_ud.sv
// Up/down Gray counter with clear, Gray-coded load and wrap/saturate end behaviour.
// Binary and Gray registers update on the same edge so count never glitches.
module gray_counter_ud
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          WRAP      = 1'b1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  gray_counter_ud_if.slave bus
);

  localparam logic [WIDTH-1:0] MaxBin = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] RstBin = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RstGry = WIDTH'(bin2gray(RESET_VAL, WIDTH));

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gry_q, gry_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] step_bin;
  logic             at_end;

  gray2bin_conv #(
    .WIDTH(WIDTH)
  ) u_load_conv (
    .gray(bus.load_val),
    .bin (load_bin)
  );

  assign at_end   = bus.up ? (bin_q == MaxBin) : (bin_q == '0);
  // Modular +/-1 already lands on the opposite end, so the wrap step needs no special case.
  assign step_bin = bus.up ? (bin_q + 1'b1) : (bin_q - 1'b1);

  always_comb begin
    bin_d  = bin_q;
    gry_d  = gry_q;
    wrap_d = 1'b0;
    if (bus.clr) begin
      bin_d = '0;
      gry_d = '0;
    end else if (bus.load) begin
      bin_d = load_bin;
      gry_d = bus.load_val;
    end else if (bus.ena && (!at_end || WRAP)) begin
      bin_d  = step_bin;
      gry_d  = WIDTH'(bin2gray(32'(step_bin), WIDTH));
      wrap_d = at_end;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= RstBin;
      gry_q  <= RstGry;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gry_q  <= gry_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.count     = gry_q;
  assign bus.count_bin = bin_q;
  assign bus.tc        = at_end;
  assign bus.wrap      = wrap_q;

endmodule

// File: doc/gray_counter_ud.md
Name: gray_counter_ud

Overview:
- Parametrised up/down Gray-code counter with enable, synchronous clear, parallel load and wrap/saturate modes.
- Registered Gray output is glitch-free: one bit changes per step. Safe to send across clock domains, e.g. FIFO pointers and CDC'd sequence counters.
- Binary view of the same count is also provided for local arithmetic.
- A terminal-count flag and a wrap pulse are provided for chaining and event counting.

Parameters:
- WIDTH, 4: counter width in bits; legal range 2..32.
- WRAP, 1: 1 = wrap modulo 2^WIDTH; 0 = saturate at the end value for the current direction.
- RESET_VAL, 0: binary count value loaded on reset; must be < 2^WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  count enable; one step per cycle while high
- up  in  1  direction: 1 = increment, 0 = decrement (binary sense)
- clr  in  1  synchronous clear to binary 0
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  Gray-coded value to load
- count  out  WIDTH  registered Gray-coded count
- count_bin  out  WIDTH  registered binary equivalent of count
- tc  out  1  combinational terminal count: (up && count_bin == 2^WIDTH-1) || (!up && count_bin == 0)
- wrap  out  1  registered one-cycle pulse, cycle after a wrap step

Behaviour:
- State: binary register bin and Gray register gry, always updated on the same edge so that gry == bin ^ (bin >> 1) holds at all times.
- count = gry. count_bin = bin. No combinational path from inputs to count or count_bin.
- Reset (rst_n low, asynchronous):
  - bin = RESET_VAL; gry = RESET_VAL ^ (RESET_VAL >> 1); wrap = 0.
  - Reset is held while rst_n is low. The first update is on the first rising clk edge with rst_n high.
- Per-edge priority, highest first: clr > load > ena.
  - clr: bin = 0, gry = 0, wrap = 0. Applies regardless of load, ena and up.
  - load: bin = gray2bin(load_val), gry = load_val, wrap = 0. The next cycle's count equals load_val exactly.
  - ena, not at end value: bin = bin ± 1 modulo 2^WIDTH; gry = new bin ^ (new bin >> 1); wrap = 0.
  - ena, at end value (tc = 1), WRAP = 1: bin goes 2^WIDTH-1 -> 0 (up) or 0 -> 2^WIDTH-1 (down); wrap = 1 for exactly one cycle.
  - ena, at end value, WRAP = 0: bin and gry hold; wrap = 0.
  - None of clr, load, ena: hold; wrap = 0.
- wrap never stays high for two consecutive cycles unless consecutive wrap steps occur. For WIDTH >= 2 this happens only with a direction toggle at the boundary, e.g. up wrap then down wrap; each such step pulses wrap again.
- Single-bit property: every ena step changes exactly one bit of count, including the wrap step (Gray max 10..0 <-> 0). A saturating hold changes zero bits. clr and load may change any number of bits.
- Direction change takes effect on the same edge; there is no pipeline latency. Latency of every input to count is one cycle.
- tc reflects the current up and current count_bin combinationally. It is valid whenever rst_n is high.
- Arithmetic is unsigned WIDTH-bit. No overflow flag beyond wrap.

Decomposition:
- Shared package gray_pkg, containing:
  - functions bin2gray(width) and gray2bin(width), prefix-XOR from the MSB;
  - constant GRAY_MAX_WIDTH = 32.
- One sub-module, gray2bin_conv (parametrised WIDTH, purely combinational), used for the load path.
- The bench reuses gray_pkg functions for its reference model.

Test Plan:
- Reset and up count, WIDTH=4, RESET_VAL=0, up=1, ena=1 for 17 cycles after rst_n rises -> count = 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000. tc = 1 while count = 1000. wrap = 1 only in the cycle count returns to 0000. Exactly one bit changes per step.
- Down wrap, WRAP=1, from reset, up=0, ena=1 -> the first step gives count = 1000 (bin 15) with wrap pulse. The next step gives 1001 (bin 14).
- Saturate, WRAP=0, up=1: load load_val = 1001 (bin 14), then ena for 3 cycles -> count goes to 1000 (bin 15) and holds there. tc = 1. wrap never asserts.
- Priority in one cycle: clr=1, load=1, ena=1 -> count = 0000. Next cycle, load=1 with load_val=0110, ena=1 -> count = 0110 (load beats ena), count_bin = 0100.
- Reset mid-operation: drive rst_n low asynchronously between edges while counting with RESET_VAL=5 -> count = 0111 and count_bin = 0101 immediately, with wrap = 0. Counting resumes from 5 on the first edge after release.
- Randomised check across WIDTH in {2, 5, 8}: gry == bin ^ (bin >> 1) on every cycle, and Hamming distance between consecutive counts <= 1 whenever clr and load are low.
